sfm_max_reducer: RTL and testbench

- Streaming running-maximum stage placed directly upstream of the sfm_pipeline register slice that feeds the softmax exponent datapath.
- Consumes beats of NUM_IN floating-point lanes with per-lane strobes, grouped into vectors by last_i.
- Emits one maximum per vector, plus the count of contributing elements, over a valid/ready handshake.
- The downstream stage subtracts this maximum from every element before exponentiation.

---
 rtl/sfm_max_reducer.sv | 180 ++++++++++++++++++
 tb/tb_sfm_max_reducer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sfm_max_reducer.sv
// Streaming running-maximum over strobed float lanes, one max/count result per vector.
// Optional NaN propagation is enabled by defining SFM_MAX_NAN_PROP_EN.
module sfm_max_reducer #(
  parameter int EXP_BITS  = 8,
  parameter int MAN_BITS  = 7,
  parameter int NUM_IN    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  enable_i,
  input  logic                                  clear_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [NUM_IN*(1+EXP_BITS+MAN_BITS)-1:0] data_i,
  input  logic [NUM_IN-1:0]                     strb_i,
  input  logic                                  last_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [EXP_BITS+MAN_BITS:0]            max_o,
  output logic [CNT_WIDTH-1:0]                  count_o
);

  localparam int WIDTH = 1 + EXP_BITS + MAN_BITS;
  localparam int PC_W  = $clog2(NUM_IN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};

  // Maps floats onto unsigned integers with the same ordering (-inf lowest, -0 < +0).
  function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ~v : {1'b1, v[WIDTH-2:0]};
  endfunction

  logic [1:0]           state_q, state_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     run_max_q, run_max_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;

  logic [NUM_IN-1:0]    lane_nan;
  logic [NUM_IN-1:0]    lane_use;
  logic [WIDTH-1:0]     tree_max;
  logic [PC_W-1:0]      tree_cnt;
  logic [WIDTH-1:0]     base_max, merged_max;
  logic [CNT_WIDTH-1:0] base_cnt, merged_cnt;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic                 accept;
  logic [WIDTH-1:0]     final_max;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign lane_nan[gi] = strb_i[gi]
                          & (&data_i[gi*WIDTH+MAN_BITS +: EXP_BITS])
                          & (|data_i[gi*WIDTH +: MAN_BITS]);
`ifdef SFM_MAX_NAN_PROP_EN
      assign lane_use[gi] = strb_i[gi];
`else
      assign lane_use[gi] = strb_i[gi] & ~lane_nan[gi];
`endif
    end
  endgenerate

  always_comb begin
    tree_max = NEG_INF;
    tree_cnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (lane_use[i]) begin
        tree_cnt = tree_cnt + PC_W'(1);
        if (order_key(data_i[i*WIDTH +: WIDTH]) > order_key(tree_max))
          tree_max = data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // In IDLE the running contribution is the neutral element, whatever the registers hold.
  assign base_max   = (state_q == S_ACCUM) ? run_max_q : NEG_INF;
  assign base_cnt   = (state_q == S_ACCUM) ? run_cnt_q : '0;
  assign merged_max = (order_key(tree_max) > order_key(base_max)) ? tree_max : base_max;
  assign cnt_sum    = {1'b0, base_cnt} + (CNT_WIDTH+1)'(tree_cnt);
  assign merged_cnt = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];

  assign ready_o = enable_i & (state_q != S_HOLD);
  assign accept  = valid_i & ready_o;

`ifdef SFM_MAX_NAN_PROP_EN
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
  logic nan_q, nan_d, merged_nan;
  assign merged_nan = ((state_q == S_ACCUM) & nan_q) | (|lane_nan);
  assign final_max  = merged_nan ? QNAN : merged_max;
`else
  assign final_max  = merged_max;
`endif

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_cnt_d = run_cnt_q;
`ifdef SFM_MAX_NAN_PROP_EN
    nan_d     = nan_q;
`endif
    if (clear_i) begin
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      run_max_d = NEG_INF;
      run_cnt_d = '0;
`ifdef SFM_MAX_NAN_PROP_EN
      nan_d     = 1'b0;
`endif
    end else if (enable_i) begin
      case (state_q)
        S_HOLD: begin
          if (ready_i) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          if (accept) begin
            if (last_i) begin
              max_d     = final_max;
              cnt_d     = merged_cnt;
              valid_d   = 1'b1;
              run_max_d = NEG_INF;
              run_cnt_d = '0;
`ifdef SFM_MAX_NAN_PROP_EN
              nan_d     = 1'b0;
`endif
              state_d   = S_HOLD;
            end else begin
              run_max_d = merged_max;
              run_cnt_d = merged_cnt;
`ifdef SFM_MAX_NAN_PROP_EN
              nan_d     = merged_nan;
`endif
              state_d   = S_ACCUM;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      max_q     <= NEG_INF;
      cnt_q     <= '0;
      run_max_q <= NEG_INF;
      run_cnt_q <= '0;
`ifdef SFM_MAX_NAN_PROP_EN
      nan_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_cnt_q <= run_cnt_d;
`ifdef SFM_MAX_NAN_PROP_EN
      nan_q     <= nan_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign max_o   = max_q;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_sfm_max_reducer.sv
// Scoreboard bench for sfm_max_reducer: stimulus pushes expected results, a monitor pops on handshake.
module tb_sfm_max_reducer;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]  strb_i = '0;
  logic          last_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [W-1:0]  max_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  sfm_max_reducer #(.EXP_BITS(8), .MAN_BITS(7), .NUM_IN(N), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .strb_i(strb_i),
    .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i), .max_o(max_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // Result monitor: a handshake completes at the next rising edge.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i && enable_i && !clear_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got max %h count %0d expected none", max_o, count_o);
      end else begin
        mon_e = exp_q.pop_front();
        $display("result max=%h count=%0d (expected max=%h count=%0d)",
                 max_o, count_o, mon_e[31:16], mon_e[15:0]);
        chk("result_max", {16'h0, max_o}, {16'h0, mon_e[31:16]});
        chk("result_count", {16'h0, count_o}, {16'h0, mon_e[15:0]});
      end
    end
  end

  task automatic send_beat(input logic [N*W-1:0] d, input logic [N-1:0] s, input logic l);
    int t = 0;
    data_i  = d;
    strb_i  = s;
    last_i  = l;
    valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      t++;
    end while (!ready_o && t < 50);
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready_o 0 expected 1");
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    strb_i  = '0;
  endtask

  task automatic drain();
    int t = 0;
    ready_i = 1'b1;
    do begin
      @(negedge clk_i);
      t++;
    end while (!valid_o && t < 50);
    if (!valid_o) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got valid_o 0 expected 1");
    end
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset_valid", {31'h0, valid_o}, 32'h0);
    chk("reset_max", {16'h0, max_o}, 32'h0000FF80);
    chk("reset_count", {16'h0, count_o}, 32'h0);
    chk("reset_ready", {31'h0, ready_o}, 32'h1);
    @(posedge clk_i);
    #1;

    // Single beat, all lanes
    exp_q.push_back({16'h4060, 16'd4});
    send_beat(pk(16'h3F80, 16'hC000, 16'h4060, 16'h3F00), 4'b1111, 1'b1);
    chk("latency_valid", {31'h0, valid_o}, 32'h1);
    drain();

    // Three-beat vector with backpressure
    exp_q.push_back({16'h40E0, 16'd12});
    send_beat(pk(16'h3F80, 16'h3F00, 16'hC000, 16'h4060), 4'b1111, 1'b0);
    send_beat(pk(16'h40E0, 16'h3F80, 16'h3F80, 16'h3F80), 4'b1111, 1'b0);
    send_beat(pk(16'h3F00, 16'h3F00, 16'h3F00, 16'h3F00), 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hold_ready", {31'h0, ready_o}, 32'h0);
      chk("hold_valid", {31'h0, valid_o}, 32'h1);
      chk("hold_max", {16'h0, max_o}, 32'h000040E0);
    end
    @(posedge clk_i);
    #1;
    drain();
    chk("ready_after_hs", {31'h0, ready_o}, 32'h1);

    // Signed zeros: +0 beats -0
    exp_q.push_back({16'h0000, 16'd2});
    send_beat(pk(16'h8000, 16'h0000, 16'h4110, 16'h4110), 4'b0011, 1'b1);
    drain();

    // Empty vector: strobes all zero, data ignored
    exp_q.push_back({16'hFF80, 16'd0});
    send_beat(pk(16'h4110, 16'h4110, 16'h4110, 16'h4110), 4'b0000, 1'b0);
    send_beat(pk(16'h4110, 16'h4110, 16'h4110, 16'h4110), 4'b0000, 1'b1);
    drain();

    // Clear mid-vector discards 9.0
    send_beat(pk(16'h4110, 16'h0, 16'h0, 16'h0), 4'b0001, 1'b0);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    chk("clear_valid", {31'h0, valid_o}, 32'h0);
    exp_q.push_back({16'h3F80, 16'd1});
    send_beat(pk(16'h3F80, 16'h0, 16'h0, 16'h0), 4'b0001, 1'b1);
    drain();

    // NaN lane alongside 2.0
`ifdef SFM_MAX_NAN_PROP_EN
    exp_q.push_back({16'h7FC0, 16'd2});
`else
    exp_q.push_back({16'h4000, 16'd1});
`endif
    send_beat(pk(16'h7FC1, 16'h4000, 16'h0, 16'h0), 4'b0011, 1'b1);
    drain();

    // enable_i low freezes HOLD even with ready_i high
    exp_q.push_back({16'h4000, 16'd1});
    send_beat(pk(16'h4000, 16'h0, 16'h0, 16'h0), 4'b0001, 1'b1);
    enable_i = 1'b0;
    ready_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("dis_valid", {31'h0, valid_o}, 32'h1);
      chk("dis_ready", {31'h0, ready_o}, 32'h0);
      chk("dis_max", {16'h0, max_o}, 32'h00004000);
    end
    @(posedge clk_i);
    #1 enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("en_handshake", {31'h0, valid_o}, 32'h0);
    ready_i = 1'b0;

    // Count saturation: 16384 beats of 4 lanes would reach 65536
    exp_q.push_back({16'h3F80, 16'hFFFF});
    for (int i = 0; i < 16383; i++)
      send_beat(pk(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80), 4'b1111, 1'b0);
    send_beat(pk(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80), 4'b1111, 1'b1);
    drain();

    // Asynchronous reset while in HOLD
    send_beat(pk(16'h4110, 16'h0, 16'h0, 16'h0), 4'b0001, 1'b1);
    chk("pre_reset_valid", {31'h0, valid_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_max", {16'h0, max_o}, 32'h0000FF80);
    chk("rst_count", {16'h0, count_o}, 32'h0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // After reset, a new vector must not see the lost partial
    exp_q.push_back({16'h3F80, 16'd1});
    send_beat(pk(16'h3F80, 16'h0, 16'h0, 16'h0), 4'b0001, 1'b1);
    drain();

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
